// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the scanner state encoding, the (row, column) -> hex code map that
// matches the seven-segment display encoding, the column drive pattern used
// at reset, and two small helpers for row priority and column drive.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  // Indexed [row][col]; '*' maps to E and '#' maps to F.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  localparam logic [3:0] COL_IDLE = 4'b1110;

  // Several rows low at once: the lowest row index wins.
  function automatic logic [1:0] lowest_row(input logic [3:0] sample);
    logic [1:0] idx;
    if (!sample[0]) begin
      idx = 2'd0;
    end else if (!sample[1]) begin
      idx = 2'd1;
    end else if (!sample[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Active-low drive with exactly one column low.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals asynchronous to clk.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, forces both stages to all-ones
//           (the idle level of pulled-up active-low lines)
//   d     - asynchronous input
//   q     - synchronised output, two cycles behind d
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; only the second stage is used downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with per-dwell debouncing.
// Drives one column low at a time, samples the synchronised rows once per
// column dwell, debounces both press and release, and reports the accepted
// key as a hex code with a one-cycle valid pulse and a held level.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-high reset
//   row       - keypad rows, active-low, asynchronous to clk
//   col       - column drive, active-low, exactly one bit low
//   key_code  - hex code of the last accepted key (held between presses)
//   key_valid - one-cycle pulse when a new key is accepted
//   key_held  - high from acceptance until the release is debounced
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div;
  logic             tick;
  state_t           state;
  logic [1:0]       col_idx;
  logic [CNT_W-1:0] count;
  logic [3:0]       latched_row;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_s)
  );

  assign tick = (div == DIV_LAST);

  // Dwell divider: one tick per column dwell; all sampling happens on ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Scanner FSM. The column index is not changed while a key is being
  // debounced or held, so it doubles as the latched column. The completed
  // count is acted on in the cycle after the tick that reached it, which keeps
  // key_valid a registered single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      count       <= '0;
      latched_row <= 4'b1111;
      col         <= COL_IDLE;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            if (row_s != 4'b1111) begin
              latched_row <= row_s;
              count       <= CNT_W'(1);
              state       <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
              col     <= col_drive(col_idx + 2'd1);
            end
          end
        end
        DEBOUNCE: begin
          if (count == CNT_DONE) begin
            key_code  <= KEY_MAP[lowest_row(latched_row)][col_idx];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            count     <= '0;
            state     <= HELD;
          end else if (tick) begin
            if (row_s == latched_row) begin
              count <= count + 1'b1;
            end else begin
              count <= '0;
              state <= SCAN;
            end
          end
        end
        HELD: begin
          if (count == CNT_DONE) begin
            key_held <= 1'b0;
            count    <= '0;
            col_idx  <= col_idx + 2'd1;
            col      <= col_drive(col_idx + 2'd1);
            state    <= SCAN;
          end else if (tick) begin
            if (row_s == 4'b1111) begin
              count <= count + 1'b1;
            end else begin
              count <= '0;
            end
          end
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A keypad model pulls row[r] low while col[c] is low and key (r,c) is
// pressed. Stimulus pushes expected key codes into a queue; a monitor pops
// and compares whenever key_valid is seen.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;
  logic [3:0]  exp_q [$];
  int          checks;
  int          errors;
  logic        prev_valid;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: pressed[r*4+c] shorts row r to column c.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(pressed[r*4 +: 4] & ~col);
    end
  end

  // Scoreboard monitor: every valid pulse must match the oldest expected code
  // and must never follow a valid pulse in the previous cycle.
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_valid: got key_valid=1 code=%h, required no pulse", key_code);
      end else begin
        logic [3:0] exp_code;
        exp_code = exp_q.pop_front();
        if (key_code !== exp_code) begin
          errors++;
          $display("[TB] FAIL key_code: got %h, required %h", key_code, exp_code);
        end
      end
      checks++;
      if (prev_valid) begin
        errors++;
        $display("[TB] FAIL valid_width: got key_valid high 2 cycles, required 1");
      end
    end
    prev_valid = key_valid;
  end

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic waitForHeld(input string name, input logic level, input int bound, output int n);
    n = 0;
    while (key_held !== level && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_held !== level) begin
      errors++;
      $display("[TB] FAIL %s: got key_held=%b after %0d cycles, required %b", name, key_held, n, level);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic down);
    pressed[r*4 + c] = down;
  endtask

  initial begin
    int n;
    logic [3:0] exp_col;
    checks     = 0;
    errors     = 0;
    prev_valid = 1'b0;
    pressed    = '0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset_col", col, 4'b1110);
    checkOutput("reset_code", key_code, 4'h0);
    checkOutput("reset_held", {3'b0, key_held}, 4'h0);
    checkOutput("reset_valid", {3'b0, key_valid}, 4'h0);

    for (int k = 0; k < 200; k++) begin
      if (k % 4 == 0) begin
        exp_col = ~(4'b0001 << ((k / 4) % 4));
        checkOutput("idle_col", col, exp_col);
      end
      @(negedge clk);
    end
    checkOutput("idle_code", key_code, 4'h0);
    checkOutput("idle_held", {3'b0, key_held}, 4'h0);

    exp_q.push_back(4'h6);
    applyStimulus(1, 2, 1'b1);
    waitForHeld("press_r1c2", 1'b1, 31, n);
    checkOutput("press_col", col, 4'b1011);
    repeat (20) @(negedge clk);
    checkOutput("held_col", col, 4'b1011);
    checkOutput("held_level", {3'b0, key_held}, 4'h1);
    checkOutput("held_code", key_code, 4'h6);

    applyStimulus(1, 2, 1'b0);
    waitForHeld("release_r1c2", 1'b0, 20, n);
    checks++;
    if (n < 12 || n > 16) begin
      errors++;
      $display("[TB] FAIL release_latency: got %0d cycles, required 12..16", n);
    end
    checkOutput("resume_col", col, 4'b0111);
    repeat (12) @(negedge clk);
    checkOutput("after_release_code", key_code, 4'h6);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(3, 1, 1'b1);
      repeat (4) @(negedge clk);
      applyStimulus(3, 1, 1'b0);
      repeat (4) @(negedge clk);
    end
    checkOutput("bounce_held", {3'b0, key_held}, 4'h0);
    exp_q.push_back(4'h0);
    applyStimulus(3, 1, 1'b1);
    waitForHeld("press_r3c1", 1'b1, 40, n);
    checkOutput("bounce_code", key_code, 4'h0);
    checkOutput("bounce_col", col, 4'b1101);
    applyStimulus(3, 1, 1'b0);
    waitForHeld("release_r3c1", 1'b0, 20, n);

    exp_q.push_back(4'h1);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(2, 0, 1'b1);
    waitForHeld("press_multi", 1'b1, 40, n);
    applyStimulus(0, 3, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("multi_code", key_code, 4'h1);
    checkOutput("multi_held", {3'b0, key_held}, 4'h1);
    checkOutput("multi_col", col, 4'b1110);
    pressed = '0;
    waitForHeld("release_multi", 1'b0, 20, n);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 3, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("pre_reset_held", {3'b0, key_held}, 4'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_col", col, 4'b1110);
    checkOutput("midrst_held", {3'b0, key_held}, 4'h0);
    checkOutput("midrst_valid", {3'b0, key_valid}, 4'h0);
    checkOutput("midrst_code", key_code, 4'h0);
    exp_q.push_back(4'hA);
    waitForHeld("press_r0c3", 1'b1, 40, n);
    checkOutput("redetect_code", key_code, 4'hA);
    applyStimulus(0, 3, 1'b0);
    waitForHeld("release_r0c3", 1'b0, 20, n);
    repeat (8) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_pulses: got %0d unmatched expected codes, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
